// File: rtl/usb_in_scheduler_if.sv
// Scheduler-side bus between usb_in_scheduler, USB rx/tx and ether2usb FIFO.
// master drives tokens/FIFO status, slave is the scheduler.
interface usb_in_scheduler_if;
    logic        in_token;
    logic        ack_rcvd;
    logic        frame_done;
    logic [10:0] frame_len;
    logic        fifo_empty;
    logic        tx_byte_req;
    logic        tx_complete;
    logic        tx_enable;
    logic        handshake_prep;
    logic [1:0]  handshake;
    logic        read_enable;
    logic [2:0]  frames_pending;
    logic        len_overflow;
    logic        xfer_error;

    modport master (
        output in_token, ack_rcvd, frame_done, frame_len,
        output fifo_empty, tx_byte_req, tx_complete,
        input  tx_enable, handshake_prep, handshake, read_enable,
        input  frames_pending, len_overflow, xfer_error
    );

    modport slave (
        input  in_token, ack_rcvd, frame_done, frame_len,
        input  fifo_empty, tx_byte_req, tx_complete,
        output tx_enable, handshake_prep, handshake, read_enable,
        output frames_pending, len_overflow, xfer_error
    );
endinterface

// File: rtl/usb_in_scheduler.sv
// USB IN scheduler: queues Ethernet frame lengths and answers IN tokens
// with DATA0/DATA1 packets from the ether2usb FIFO, NAK, or timeout flush.
module usb_in_scheduler #(
    parameter int MAX_PKT     = 64,
    parameter int LEN_DEPTH   = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_in_scheduler_if.slave  bus
);
    localparam int AW = $clog2(LEN_DEPTH);
    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_NAK, S_SEND, S_WAIT, S_FLUSH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_q [LEN_DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [2:0]  r_cnt;
    logic        r_ovf;
    logic [10:0] r_rem;
    logic [10:0] r_pkt;
    logic        r_final;
    logic        r_active;
    logic        r_toggle;
    logic [CW-1:0] r_ack_cnt;

    logic        w_empty;
    logic        w_full;
    logic [10:0] w_rem_start;
    logic [10:0] w_pkt_start;
    logic        w_start;
    logic        w_byte;
    logic        w_flush_rd;
    logic        w_ack;
    logic        w_tmo;
    logic        w_flush_end;
    logic        w_pop;
    logic        w_push;

    assign w_empty     = (r_cnt == 3'd0);
    assign w_full      = (r_cnt == 3'(LEN_DEPTH));
    // A frame already in progress resumes from remaining, else from queue head.
    assign w_rem_start = r_active ? r_rem : r_q[r_rd];
    assign w_pkt_start = (w_rem_start > 11'(MAX_PKT)) ? 11'(MAX_PKT)
                                                      : w_rem_start;
    assign w_start     = (r_state == S_IDLE) && bus.in_token && !w_empty;
    assign w_byte      = (r_state == S_SEND) && bus.tx_byte_req &&
                         (r_pkt != 11'd0) && !bus.fifo_empty;
    assign w_flush_rd  = (r_state == S_FLUSH) && (r_rem != 11'd0) &&
                         !bus.fifo_empty;
    assign w_flush_end = (r_state == S_FLUSH) && (r_rem == 11'd0);
    assign w_ack       = (r_state == S_WAIT) && bus.ack_rcvd;
    assign w_tmo       = (r_state == S_WAIT) && !bus.ack_rcvd &&
                         (r_ack_cnt == CW'(ACK_TIMEOUT - 1));
    assign w_pop       = (w_ack && r_final) || w_flush_end;
    assign w_push      = bus.frame_done && (!w_full || w_pop);

    assign bus.frames_pending = r_cnt;
    assign bus.len_overflow   = r_ovf;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.in_token) w_next = w_empty ? S_NAK : S_SEND;
            S_NAK:   w_next = S_IDLE;
            S_SEND:  if (bus.tx_complete) w_next = S_WAIT;
            S_WAIT: begin
                if (bus.ack_rcvd) w_next = S_IDLE;
                else if (w_tmo)   w_next = S_FLUSH;
            end
            S_FLUSH: if (r_rem == 11'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; pops follow the request in the same cycle.
    always_comb begin
        bus.tx_enable      = 1'b0;
        bus.handshake_prep = 1'b0;
        bus.handshake      = 2'b00;
        bus.read_enable    = 1'b0;
        bus.xfer_error     = 1'b0;
        unique case (r_state)
            S_NAK: begin
                bus.handshake_prep = 1'b1;
                bus.handshake      = 2'b10;
            end
            S_SEND: begin
                bus.tx_enable   = 1'b1;
                bus.handshake   = {1'b0, r_toggle};
                bus.read_enable = w_byte;
            end
            S_WAIT:  bus.xfer_error  = w_tmo;
            S_FLUSH: bus.read_enable = w_flush_rd;
            default: ;
        endcase
    end

    // Frame-length storage; contents need no reset, occupancy does.
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wr] <= bus.frame_len;
    end

    // Queue pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= 3'd0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 3'd1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 3'd1;
            if (bus.frame_done && !w_push) r_ovf <= 1'b1;
        end
    end

    // Per-frame byte accounting, data toggle and ACK wait counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rem     <= 11'd0;
            r_pkt     <= 11'd0;
            r_final   <= 1'b0;
            r_active  <= 1'b0;
            r_toggle  <= 1'b0;
            r_ack_cnt <= '0;
        end else begin
            if (w_start) begin
                r_rem    <= w_rem_start;
                r_pkt    <= w_pkt_start;
                // A full-size packet is never final: short-packet rule.
                r_final  <= (w_rem_start < 11'(MAX_PKT));
                r_active <= 1'b1;
            end else if (w_byte) begin
                r_pkt <= r_pkt - 11'd1;
                r_rem <= r_rem - 11'd1;
            end else if (w_flush_rd) begin
                r_rem <= r_rem - 11'd1;
            end
            if (w_pop) r_active <= 1'b0;
            if (w_ack)            r_toggle <= ~r_toggle;
            else if (w_flush_end) r_toggle <= 1'b0;
            if (r_state == S_SEND && bus.tx_complete) r_ack_cnt <= '0;
            else if (r_state == S_WAIT)               r_ack_cnt <= r_ack_cnt + 1'b1;
        end
    end

    a_stale_byte: assert property (@(posedge clk) disable iff (!n_rst)
        !(r_state == S_SEND && bus.tx_byte_req && bus.fifo_empty));

endmodule

// File: tb/tb_usb_in_scheduler.sv
// Scoreboard bench for usb_in_scheduler: driver queues expected events,
// a negedge monitor reconstructs NAK/DATA/XERR/FLUSH events and compares.
module tb_usb_in_scheduler;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];

    usb_in_scheduler_if bus();

    usb_in_scheduler #(
        .MAX_PKT(64), .LEN_DEPTH(4), .ACK_TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int ev(input int kind, input int pid, input int cnt);
        return (kind << 16) | (pid << 12) | cnt;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic got_ev(input int v);
        int e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got %0h expected none", v);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard_event", v, e);
        end
    endtask

    int m_prev = 0;
    int m_pid = 0;
    int m_cnt = 0;
    int m_flush = 0;
    int m_fcnt = 0;

    always @(negedge clk) begin
        if (!n_rst) begin
            m_prev = 0; m_cnt = 0; m_flush = 0; m_fcnt = 0;
        end else begin
            if (bus.handshake_prep) got_ev(ev(1, int'(bus.handshake), 0));
            if (bus.tx_enable && m_prev == 0) begin
                m_pid = int'(bus.handshake);
                m_cnt = 0;
            end
            if (bus.tx_enable && bus.read_enable) m_cnt++;
            if (!bus.tx_enable && m_prev != 0) got_ev(ev(2, m_pid, m_cnt));
            if (bus.xfer_error) begin
                got_ev(ev(3, 0, 0));
                m_flush = 1;
                m_fcnt = 0;
            end else if (m_flush != 0) begin
                if (bus.read_enable) m_fcnt++;
                else begin
                    got_ev(ev(4, 0, m_fcnt));
                    m_flush = 0;
                end
            end else if (!bus.tx_enable && bus.read_enable) begin
                got_ev(ev(9, 0, 0));
            end
            m_prev = bus.tx_enable ? 1 : 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit tok, input bit ack, input bit fd,
                         input bit req, input bit cmp,
                         input logic [10:0] len);
        @(posedge clk);
        #1;
        bus.in_token    = tok;
        bus.ack_rcvd    = ack;
        bus.frame_done  = fd;
        bus.tx_byte_req = req;
        bus.tx_complete = cmp;
        bus.frame_len   = len;
        @(posedge clk);
        #1;
        bus.in_token    = 1'b0;
        bus.ack_rcvd    = 1'b0;
        bus.frame_done  = 1'b0;
        bus.tx_byte_req = 1'b0;
        bus.tx_complete = 1'b0;
    endtask

    task automatic frame(input logic [10:0] len);
        pulse(0, 0, 1, 0, 0, len);
    endtask

    task automatic ack();
        pulse(0, 1, 0, 0, 0, 11'd0);
    endtask

    task automatic nak();
        exp_q.push_back(ev(1, 2, 0));
        pulse(1, 0, 0, 0, 0, 11'd0);
        check("nak_latency", int'(bus.handshake_prep), 1);
    endtask

    task automatic send_packet(input int nreq, input int pid, input int pops);
        exp_q.push_back(ev(2, pid, pops));
        pulse(1, 0, 0, 0, 0, 11'd0);
        check("tx_enable_latency", int'(bus.tx_enable), 1);
        repeat (nreq) pulse(0, 0, 0, 1, 0, 11'd0);
        pulse(0, 0, 0, 0, 1, 11'd0);
    endtask

    function automatic int outs();
        return int'({bus.tx_enable, bus.handshake_prep, bus.handshake,
                     bus.read_enable, bus.frames_pending,
                     bus.len_overflow, bus.xfer_error});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_token = 1'b0; bus.ack_rcvd = 1'b0; bus.frame_done = 1'b0;
        bus.frame_len = 11'd0; bus.fifo_empty = 1'b0;
        bus.tx_byte_req = 1'b0; bus.tx_complete = 1'b0;
        idle(3);
        check("reset_outputs", outs(), 0);
        n_rst = 1'b1;
        idle(2);
        check("idle_outputs", outs(), 0);

        nak();
        idle(3);

        frame(11'd100);
        check("pending_after_100", int'(bus.frames_pending), 1);
        send_packet(64, 0, 64);
        ack();
        send_packet(37, 1, 36);
        check("pending_before_last_ack", int'(bus.frames_pending), 1);
        ack();
        check("pending_after_100_done", int'(bus.frames_pending), 0);
        idle(2);

        frame(11'd64);
        send_packet(64, 0, 64);
        ack();
        check("pending_after_full_pkt", int'(bus.frames_pending), 1);
        send_packet(3, 1, 0);
        ack();
        check("pending_after_zlp", int'(bus.frames_pending), 0);
        idle(2);

        frame(11'd200);
        send_packet(64, 0, 64);
        exp_q.push_back(ev(3, 0, 0));
        exp_q.push_back(ev(4, 0, 136));
        n = 0;
        while (n < 1100) begin
            @(negedge clk);
            n++;
            if (bus.xfer_error) break;
        end
        check("xfer_error_latency", n, 1024);
        idle(150);
        check("pending_after_flush", int'(bus.frames_pending), 0);
        nak();
        idle(3);

        frame(11'd10);
        frame(11'd20);
        frame(11'd30);
        frame(11'd40);
        check("overflow_before_full", int'(bus.len_overflow), 0);
        frame(11'd50);
        check("pending_saturated", int'(bus.frames_pending), 4);
        check("len_overflow_set", int'(bus.len_overflow), 1);
        send_packet(10, 0, 10);
        pulse(0, 1, 1, 0, 0, 11'd5);
        check("pending_push_pop", int'(bus.frames_pending), 4);
        check("overflow_sticky", int'(bus.len_overflow), 1);
        send_packet(20, 1, 20);
        ack();
        send_packet(30, 0, 30);
        ack();
        send_packet(40, 1, 40);
        ack();
        send_packet(6, 0, 5);
        ack();
        check("pending_drained", int'(bus.frames_pending), 0);
        idle(3);

        frame(11'd50);
        pulse(1, 0, 0, 0, 0, 11'd0);
        check("send_before_reset", int'(bus.tx_enable), 1);
        repeat (3) pulse(0, 0, 0, 1, 0, 11'd0);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        idle(2);
        n_rst = 1'b1;
        idle(2);
        nak();
        idle(10);

        while (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_event: got none expected %0h",
                     exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
